// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_pkg;

  localparam int NREGS = 32;
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic {
    CLEAR,
    RUN
  } wr_state_t;

  typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// Combinational round-robin arbiter: search starts one past `last` and wraps,
// producing a one-hot grant and its encoded index.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the regfile write port; drops writes to XZR.
// Define REGFILE_CLEAR_EN to zero X0..X30 after every reset.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     dropped,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  wr_state_t       state_reg;
  logic [IW-1:0]   rr_last_reg;
  logic            we3_reg;
  logic [AW-1:0]   wa3_reg;
  logic [DW-1:0]   wd3_reg;
  logic [IW-1:0]   grant_reg;
  logic            dropped_reg;
`ifdef REGFILE_CLEAR_EN
  reg_addr_t       clr_ptr_reg;
`endif

  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [NREQ-1:0] xzr_hit;

  // Grants are suppressed during reset and while the clear sequence owns the port.
  assign arb_req = (state_reg == RUN && !reset) ? req_valid : '0;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req  (arb_req),
    .last (rr_last_reg),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_xzr
      assign xzr_hit[gi] = (req_addr[gi] == AW'(XZR));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_reg     <= 1'b0;
      wa3_reg     <= '0;
      wd3_reg     <= '0;
      grant_reg   <= '0;
      dropped_reg <= 1'b0;
      rr_last_reg <= IW'(NREQ - 1);
`ifdef REGFILE_CLEAR_EN
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
`else
      state_reg   <= RUN;
`endif
    end else begin
      we3_reg     <= 1'b0;
      dropped_reg <= 1'b0;
      case (state_reg)
`ifdef REGFILE_CLEAR_EN
        CLEAR: begin
          we3_reg     <= 1'b1;
          wa3_reg     <= AW'(clr_ptr_reg);
          wd3_reg     <= '0;
          clr_ptr_reg <= clr_ptr_reg + 5'd1;
          // X31 is hardwired zero, so the sweep stops after X30.
          if (clr_ptr_reg == reg_addr_t'(NREGS - 2)) begin
            state_reg <= RUN;
          end
        end
`endif
        default: begin
          if (arb_any) begin
            rr_last_reg <= arb_idx;
            grant_reg   <= arb_idx;
            if (xzr_hit[arb_idx]) begin
              dropped_reg <= 1'b1;
            end else begin
              we3_reg <= 1'b1;
              wa3_reg <= req_addr[arb_idx];
              wd3_reg <= req_data[arb_idx];
            end
          end
        end
      endcase
    end
  end

  assign req_ready = arb_gnt;
  assign we3       = we3_reg;
  assign wa3       = wa3_reg;
  assign wd3       = wd3_reg;
  assign grant_id  = grant_reg;
  assign dropped   = dropped_reg;
`ifdef REGFILE_CLEAR_EN
  assign busy      = (state_reg == CLEAR);
`else
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a transaction-level model.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 64;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0][AW-1:0] req_addr = '0;
  logic [NREQ-1:0][DW-1:0] req_data = '0;
  logic [NREQ-1:0]         req_ready;
  logic                    we3;
  logic [AW-1:0]           wa3;
  logic [DW-1:0]           wd3;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    dropped;
  logic                    busy;

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .grant_id(grant_id), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending request per requester plus expected port state.
  logic            p_valid [NREQ];
  logic [AW-1:0]   p_addr  [NREQ];
  logic [DW-1:0]   p_data  [NREQ];
  int              m_last;
  logic            exp_we, exp_drop;
  logic [AW-1:0]   exp_wa;
  logic [DW-1:0]   exp_wd;
  int              exp_gid;
  int              grants [NREQ];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last   = NREQ - 1;
    exp_we   = 1'b0;
    exp_drop = 1'b0;
    exp_wa   = '0;
    exp_wd   = '0;
    exp_gid  = 0;
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
  endtask

  // Runs `ncyc` clear edges starting right after reset release.
  task automatic do_clear(input int ncyc);
    req_valid = '1;
    for (int k = 1; k <= ncyc; k++) begin
      #1;
      check_val("clr_ready", 64'(req_ready), 64'(0));
      check_val("clr_busy_pre", 64'(busy), 64'(1));
      @(posedge clk); #1;
      check_val("clr_we3", 64'(we3), 64'(1));
      check_val("clr_wa3", 64'(wa3), 64'(k - 1));
      check_val("clr_wd3", 64'(wd3), 64'(0));
      check_val("clr_busy", 64'(busy), 64'(k < 31));
      $display("[TB] clear edge %0d wa3=%0d busy=%0b", k, wa3, busy);
    end
  endtask

  task automatic run_cycles(input int n, input int mode);
    int g, c;
    logic [NREQ-1:0] exp_ready;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_valid[i] && (mode == 1 || $urandom_range(0, 2) == 0)) begin
          p_valid[i] = 1'b1;
          if (mode == 1) p_addr[i] = AW'(i + 1);
          else if ($urandom_range(0, 4) == 0) p_addr[i] = 5'd31;
          else p_addr[i] = AW'($urandom_range(0, 30));
          p_data[i] = {$urandom, $urandom};
        end
        req_valid[i] = p_valid[i];
        req_addr[i]  = p_addr[i];
        req_data[i]  = p_data[i];
      end
      #1;
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (g < 0 && p_valid[c]) g = c;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check_val("ready", 64'(req_ready), 64'(exp_ready));
      if (g >= 0) begin
        m_last = g;
        grants[g]++;
        p_valid[g] = 1'b0;
        exp_gid = g;
        if (p_addr[g] == 5'd31) begin
          exp_we = 1'b0; exp_drop = 1'b1;
        end else begin
          exp_we = 1'b1; exp_drop = 1'b0;
          exp_wa = p_addr[g]; exp_wd = p_data[g];
        end
      end else begin
        exp_we = 1'b0; exp_drop = 1'b0;
      end
      @(posedge clk); #1;
      check_val("we3", 64'(we3), 64'(exp_we));
      check_val("dropped", 64'(dropped), 64'(exp_drop));
      check_val("wa3", 64'(wa3), 64'(exp_wa));
      check_val("wd3", wd3, exp_wd);
      check_val("busy", 64'(busy), 64'(0));
      if (exp_we) check_val("grant_id", 64'(grant_id), 64'(exp_gid));
      $display("[TB] cyc grant=%0d we3=%0b wa3=%0d wd3=%0h dropped=%0b", g, we3, wa3, wd3, dropped);
    end
  endtask

  task automatic reset_state_checks();
    check_val("rst_we3", 64'(we3), 64'(0));
    check_val("rst_wa3", 64'(wa3), 64'(0));
    check_val("rst_wd3", 64'(wd3), 64'(0));
    check_val("rst_gid", 64'(grant_id), 64'(0));
    check_val("rst_dropped", 64'(dropped), 64'(0));
`ifdef REGFILE_CLEAR_EN
    check_val("rst_busy", 64'(busy), 64'(1));
`else
    check_val("rst_busy", 64'(busy), 64'(0));
`endif
  endtask

  task automatic release_reset();
    reset = 1'b0;
    model_reset();
`ifdef REGFILE_CLEAR_EN
    do_clear(31);
    exp_we = 1'b1; exp_wa = 5'd30; exp_wd = '0;
`endif
    req_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) grants[i] = 0;
    model_reset();
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 64'(req_ready), 64'(0));
    reset_state_checks();
    $display("[TB] reset state checked");

`ifdef REGFILE_CLEAR_EN
    // Abort the clear at cycle 10; it must restart from X0.
    reset = 1'b0;
    do_clear(10);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("reclr_we3", 64'(we3), 64'(0));
    check_val("reclr_wa3", 64'(wa3), 64'(0));
`endif
    release_reset();

    run_cycles(8, 1);
    check_val("fair_r0", 64'(grants[0]), 64'(4));
    check_val("fair_r1", 64'(grants[1]), 64'(4));
    run_cycles(300, 0);

    // Reset while a request is pending in RUN.
    req_valid = '1;
    req_addr[0] = 5'd7;
    #1;
    reset = 1'b1;
    #1;
    check_val("runrst_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    reset_state_checks();
    @(posedge clk); #1;
    release_reset();
    run_cycles(200, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of the 32 x 64-bit register file (`we3`/`wa3`/`wd3`) between `NREQ` independent write requesters, e.g. the ALU writeback and the load-return path. It uses round-robin arbitration behind a valid/ready handshake. It registers the winning write onto the regfile port, so it sits directly in front of `regfile`. It also discards writes to XZR (X31). Optionally, it runs a post-reset clear sequence that zeroes X0..X30.

## Interface
- `NREQ`, 2: number of write requesters (2..4).
- `AW`, 5: register address width.
- `DW`, 64: data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ x AW  per-requester destination register.
- `req_data`  in  NREQ x DW  per-requester write data.
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs on an edge where `req_valid[i] & req_ready[i]`.
- `we3`  out  1  regfile write enable (registered).
- `wa3`  out  AW  regfile write address (registered).
- `wd3`  out  DW  regfile write data (registered).
- `grant_id`  out  clog2(NREQ)  index of the requester whose write is on the port this cycle (registered).
- `dropped`  out  1  one-cycle pulse: the previous accepted write targeted X31 and was discarded.
- `busy`  out  1  clear sequence in progress; no grants.

## Operation
- States are `CLEAR` and `RUN`. Reset enters `CLEAR` if the macro is defined, otherwise `RUN`.
- `CLEAR`:
  - Counter `clr_ptr` is 0 at reset.
  - Each edge loads `we3=1`, `wa3=clr_ptr`, `wd3=0`, then increments `clr_ptr`.
  - After the edge that loads `wa3=30`, the state goes to `RUN`.
  - `req_ready` is all 0 throughout.
- `RUN`:
  - `req_ready` is combinational from `req_valid` and the round-robin pointer `rr_last`.
  - Priority search starts at `rr_last+1` and wraps modulo `NREQ`. At most one bit is set, and only if its `req_valid` is high.
  - On a transfer from requester i, `rr_last <= i`. With no transfer, `rr_last` holds.
  - If there is no transfer, the next edge loads `we3=0`. `wa3`/`wd3` hold their previous values.
- XZR rule: a transfer with `req_addr==31` is accepted (`req_ready` high), but the next edge loads `we3=0` and `dropped=1`. `wa3`/`wd3` are not updated.
- Requesters must hold `req_valid`, `req_addr` and `req_data` stable until accepted. The arbiter never withdraws `req_ready` within a cycle.
- There is no forwarding. A read of the target register in the same cycle that `we3` is high returns the old value.
- Reset values:
  - `we3=0`, `wa3=0`, `wd3=0`, `grant_id=0`, `dropped=0`.
  - `req_ready=0` while `reset` is high.
  - `busy=1` with the macro, 0 without.
  - `rr_last=NREQ-1`, so requester 0 wins first.

## Timing
- Latency: a request accepted at edge N drives `we3`/`wa3`/`wd3` during cycle N..N+1. The regfile commits it at edge N+1.
- Throughput: one write per cycle sustained.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...
- The clear sequence takes exactly 31 cycles after reset deasserts. `busy` falls on the edge that enters `RUN`, and the first grant is possible in that same cycle.
- Reset asserted mid-`CLEAR` restarts at `clr_ptr=0`. Reset asserted in `RUN` forces `we3=0` on that edge and discards any in-flight write.

## Configuration
- `REGFILE_CLEAR_EN`
  - Defined: the `CLEAR` state, `clr_ptr` and 31-cycle zeroing are present; `busy` is high during clearing.
  - Undefined: reset goes straight to `RUN`; `busy` is tied to 0; the regfile contents after reset are whatever the regfile holds.

## Structure
- Package `regfile_pkg`:
  - constants `NREGS=32` and `XZR=5'd31`;
  - typedef `wr_state_t` enum {`CLEAR`, `RUN`};
  - typedef `reg_addr_t` `logic [4:0]`.
- Sub-module `rr_arbiter`:
  - parameterized `NREQ`;
  - inputs `req`, `last`, output one-hot `gnt` plus encoded index;
  - purely combinational.
- The top level keeps `rr_last`, the state, the output registers and `clr_ptr`.

## Test plan
- Reset release, macro on: `we3=1` for 31 consecutive cycles with `wa3` = 0..30 and `wd3=0`, then `busy=0`. Every register reads 0 and X31 reads 0.
- Single requester 0 writes X5=15 at edge N: `we3=1`, `wa3=5`, `wd3=15` in cycle N+1, and `rd1` with `ra1=5` returns 15 after edge N+1.
- Both requesters continuously valid (X1=1, X2=2), `NREQ=2`: grants alternate 0,1,0,1, `grant_id` tracks them, and each `req_ready` is high every other cycle.
- Requester 1 writes X31=4: accepted, `we3=0` next cycle, `dropped=1` for one cycle, and `rd2` with `ra2=31` reads 0.
- Reset asserted at clear cycle 10, released: the sequence restarts at `wa3=0` and takes a full 31 cycles.
- Macro undefined: `busy=0` from reset, and requester 0 is granted in the first cycle after reset.
